// File: rtl/aimc_ui_arb_pkg.sv
// Shared types and defaults for the AIMC channel UI arbiter and its round-robin picker.
package aimc_ui_arb_pkg;

  localparam int ARB_N_REQ_DEF    = 4;
  localparam int ARB_RD_DEPTH_DEF = 16;
  localparam int ARB_PRIO_MAX     = 8;

  typedef logic [$clog2(ARB_N_REQ_DEF)-1:0] arb_id_t;

  typedef enum logic [1:0] {
    CMD_NOP = 2'd0,
    CMD_WR  = 2'd1,
    CMD_RD  = 2'd2,
    CMD_REF = 2'd3
  } pkt_cmd_t;

  typedef struct packed {
    pkt_cmd_t    cmd;
    logic [29:0] addr;
    logic [31:0] data;
  } pkt_t;

  // Fold an index in [0, 2n) back into [0, n).
  function automatic int rr_wrap(input int v, input int n);
    return (v >= n) ? v - n : v;
  endfunction

endpackage

// File: rtl/aimc_ui_arb_rr_arb.sv
// Round-robin picker: combinational one-hot grant starting at ptr; ptr moves past each winner.
// Pointer holds when nothing is granted.
module rr_arb
  import aimc_ui_arb_pkg::*;
#(
  parameter  int N  = ARB_N_REQ_DEF,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_id,
  output logic          gnt_vld
);

  logic [IW-1:0] ptr;

  always_comb begin
    int idx;
    gnt     = '0;
    gnt_id  = '0;
    gnt_vld = 1'b0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = rr_wrap(int'(ptr) + k, N);
      if (!gnt_vld && req[IW'(idx)]) begin
        gnt_vld         = 1'b1;
        gnt_id          = IW'(idx);
        gnt[IW'(idx)]   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (gnt_vld) begin
      ptr <= (gnt_id == IW'(N - 1)) ? '0 : gnt_id + 1'b1;
    end
  end

endmodule

// File: rtl/aimc_ui_arb.sv
// Shares one AIMC UI among N_REQ requesters; 1-cycle request-to-ui_pkt_valid, stalls on !aimc_rdy,
// reads throttled at RD_DEPTH outstanding, responses routed back in order. Priority classes: AIMC_ARB_PRIO_EN.
module aimc_ui_arb
  import aimc_ui_arb_pkg::*;
#(
  parameter  int N_REQ    = ARB_N_REQ_DEF,
  parameter  int PKT_W    = $bits(pkt_t),
  parameter  int RD_DEPTH = ARB_RD_DEPTH_DEF,
  localparam int IDW      = $clog2(N_REQ),
  localparam int PTW      = $clog2(RD_DEPTH),
  localparam int CW       = $clog2(RD_DEPTH + 1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cal_done,
  input  logic [N_REQ-1:0][PKT_W-1:0] req_pkt,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ-1:0]            req_rd,
`ifdef AIMC_ARB_PRIO_EN
  input  logic [N_REQ-1:0]            req_prio,
`endif
  output logic [N_REQ-1:0]            req_rdy,
  output logic [PKT_W-1:0]            ui_pkt,
  output logic                        ui_pkt_valid,
  input  logic                        aimc_rdy,
  input  logic [PKT_W-1:0]            aimc_pkt,
  input  logic                        aimc_pkt_valid,
  output logic [PKT_W-1:0]            rsp_pkt,
  output logic [N_REQ-1:0]            rsp_valid,
  output logic [CW-1:0]               rd_outstanding,
  output logic                        err_unexp_rsp
);

  logic             slot_free;
  logic             rd_full;
  logic [N_REQ-1:0] elig;
  logic [N_REQ-1:0] arb_req;
  logic [N_REQ-1:0] gnt;
  logic [IDW-1:0]   gnt_id;
  logic             gnt_vld;
  logic             push;
  logic             pop;

  logic [IDW-1:0]   id_mem [RD_DEPTH];
  logic [PTW-1:0]   wr_ptr;
  logic [PTW-1:0]   rd_ptr;

  assign slot_free = !ui_pkt_valid || aimc_rdy;
  // Uses the registered count: a pop this cycle only frees a read slot next cycle.
  assign rd_full   = (rd_outstanding == CW'(RD_DEPTH));

  // rst_n gating keeps req_rdy low for the whole reset window.
  always_comb begin
    elig = '0;
    for (int i = 0; i < N_REQ; i++) begin
      elig[i] = rst_n && cal_done && slot_free && req_valid[i] && (!req_rd[i] || !rd_full);
    end
  end

`ifdef AIMC_ARB_PRIO_EN
  logic [N_REQ-1:0] elig_hi;
  logic [N_REQ-1:0] elig_lo;
  logic [3:0]       prio_cnt;
  logic             force_lo;

  assign elig_hi  = elig & req_prio;
  assign elig_lo  = elig & ~req_prio;
  assign force_lo = (prio_cnt >= 4'(ARB_PRIO_MAX)) && (|elig_lo);

  always_comb begin
    arb_req = elig_lo;
    if (force_lo) begin
      arb_req = elig_lo;
    end else if (|elig_hi) begin
      arb_req = elig_hi;
    end
  end

  // Counts back-to-back high grants that overtook a waiting low requester.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_cnt <= '0;
    end else if (gnt_vld) begin
      if (!req_prio[gnt_id] || !(|elig_lo)) begin
        prio_cnt <= '0;
      end else begin
        prio_cnt <= prio_cnt + 4'd1;
      end
    end
  end
`else
  assign arb_req = elig;
`endif

  rr_arb #(.N(N_REQ)) u_rr_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (arb_req),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .gnt_vld (gnt_vld)
  );

  assign req_rdy = gnt;
  assign push    = gnt_vld && req_rd[gnt_id];
  assign pop     = aimc_pkt_valid && (rd_outstanding != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ui_pkt       <= '0;
      ui_pkt_valid <= 1'b0;
    end else if (gnt_vld) begin
      ui_pkt       <= req_pkt[gnt_id];
      ui_pkt_valid <= 1'b1;
    end else if (aimc_rdy) begin
      ui_pkt_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      id_mem[wr_ptr] <= gnt_id;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      rd_outstanding <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   rd_outstanding <= rd_outstanding + 1'b1;
        2'b01:   rd_outstanding <= rd_outstanding - 1'b1;
        default: rd_outstanding <= rd_outstanding;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_pkt       <= '0;
      rsp_valid     <= '0;
      err_unexp_rsp <= 1'b0;
    end else begin
      rsp_valid <= '0;
      if (aimc_pkt_valid) begin
        rsp_pkt <= aimc_pkt;
        if (pop) begin
          rsp_valid <= N_REQ'(1) << id_mem[rd_ptr];
        end else begin
          err_unexp_rsp <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/aimc_ui_arb.md
Name: aimc_ui_arb

Overview:
- Shares one AIMC channel user interface (ui_pkt / ui_pkt_valid / aimc_rdy) among N_REQ requesters (host ports, test engine, PIM sequencer).
- Round-robin arbitration feeds a one-entry output register toward aimc_top.
- An in-order ID FIFO records which requester issued each read, so that returning aimc_pkt responses can be routed back to that requester.
- Sits between the interconnect and aimc_top, one instance per channel.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- PKT_W, $bits(pkt_t), packet width.
- RD_DEPTH, 16, maximum outstanding reads; this is the ID FIFO depth (power of 2).

Ports:
- clk  in  1  channel clock (aclk domain).
- rst_n  in  1  asynchronous active-low reset.
- cal_done  in  1  calibration complete; no grants while low.
- req_pkt  in  N_REQ x PKT_W  request packets.
- req_valid  in  N_REQ  request valid.
- req_rd  in  N_REQ  request is a read that expects one response.
- req_rdy  out  N_REQ  request accepted (one-hot grant).
- ui_pkt  out  PKT_W  packet to aimc_top.
- ui_pkt_valid  out  1  packet valid.
- aimc_rdy  in  1  aimc_top accepts ui_pkt this cycle.
- aimc_pkt  in  PKT_W  read response from aimc_top.
- aimc_pkt_valid  in  1  response valid; cannot be back-pressured.
- rsp_pkt  out  PKT_W  registered copy of aimc_pkt, broadcast to all requesters.
- rsp_valid  out  N_REQ  one-hot response valid.
- rd_outstanding  out  $clog2(RD_DEPTH+1)  number of reads in flight.
- err_unexp_rsp  out  1  sticky: a response arrived while the ID FIFO was empty.

Behaviour:
- Reset (async assert, sync release): all outputs 0, round-robin pointer = 0, FIFO empty. The reset and initial values are identical.
- Interface: single clock, clk; asynchronous active-low reset, rst_n.
- Slot free: slot_free = !ui_pkt_valid || aimc_rdy.
- Requester i is eligible when req_valid[i] && cal_done && slot_free && (!req_rd[i] || rd_outstanding < RD_DEPTH).
- Full check uses the registered rd_outstanding. A pop in the same cycle does not unblock a read; the read is eligible from the next cycle. Writes are never blocked by a full FIFO.
- Grant:
  - Combinational.
  - Picks the first eligible requester at or after rr_ptr, wrapping modulo N_REQ.
  - req_rdy = one-hot grant.
  - On a grant to requester g, rr_ptr <= (g+1) mod N_REQ.
  - With no grant, rr_ptr holds.
- Output register:
  - On grant: ui_pkt <= req_pkt[g], ui_pkt_valid <= 1.
  - When ui_pkt_valid && aimc_rdy with no new grant: ui_pkt_valid <= 0.
  - ui_pkt is stable while ui_pkt_valid && !aimc_rdy.
  - Request-to-ui_pkt_valid latency is 1 cycle. Throughput is 1 packet/cycle while aimc_rdy is held high.
- ID FIFO:
  - Push of g occurs in the grant cycle when req_rd[g] is set.
  - Pop occurs when aimc_pkt_valid is high.
  - Simultaneous push and pop leaves the count unchanged.
  - Pointers wrap modulo RD_DEPTH.
  - AIMC returns read responses in issue order; this ordering is a channel guarantee.
- Response path:
  - rsp_pkt <= aimc_pkt and rsp_valid <= onehot(fifo_head) one cycle after aimc_pkt_valid; otherwise rsp_valid <= 0.
- Pop with FIFO empty:
  - err_unexp_rsp <= 1.
  - rsp_valid stays 0.
  - Count stays 0.
- cal_done falling mid-operation:
  - New grants stop.
  - A packet already in the output register stays valid until accepted.
  - Outstanding reads still route normally.
- Requester behaviour: requesters may drop req_valid without being granted; the arbiter holds no state per request.

Optional Feature:
- Macro: AIMC_ARB_PRIO_EN.
- Defined:
  - Adds input req_prio [N_REQ].
  - Eligible requesters with req_prio set win over all others.
  - Round-robin applies within each class, using one shared rr_ptr.
  - A high-priority class cannot starve low priority beyond PRIO_MAX=8 consecutive high grants while a low request is pending. After 8, one low grant is forced.
- Undefined: the port and counter are absent; behaviour is pure round-robin.

Decomposition:
- aimc_lib gets:
  - ARB_N_REQ_DEF and ARB_RD_DEPTH_DEF constants.
  - arb_id_t typedef (logic [$clog2(N_REQ)-1:0]).
- Sub-module rr_arb:
  - Parameterised round-robin picker plus pointer.
  - Also reused by the PIM sequencer.
- The ID FIFO is inline: a small register array.

Test Plan:
- All 4 requesters hold req_valid with writes, aimc_rdy=1 → grants in order 0,1,2,3,0 on consecutive cycles; ui_pkt_valid stays high.
- aimc_rdy=0 for 5 cycles with req0 pending → ui_pkt holds; req_rdy=0000 after the first grant; on release the next grant is req1.
- Req2 issues 16 reads, no responses → rd_outstanding=16. Read from req1 blocked (req_rdy[1]=0) while a write from req3 is granted. One response → req1 read granted the following cycle.
- Reads from req3, req0, req2 then 3 responses → rsp_valid = 1000, 0001, 0100, each 1 cycle after aimc_pkt_valid; rsp_pkt matches.
- aimc_pkt_valid with FIFO empty → err_unexp_rsp=1 sticky; rsp_valid=0. Assert rst_n mid-traffic → all outputs 0 in the same cycle.
- cal_done=0 with requests pending → no grants; raise cal_done → first grant at rr_ptr=0 next cycle.
